multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  FSM that sequences a multi-cycle RV32I datapath: one shared ALU, one memory port, immediate generator.
//  Per instruction: drives fetch/decode/execute/memory/writeback, the immediate-format select, ALU operand muxes, PC/regfile/IR write enables and the memory handshake.
//  Counts retired instructions. Traps (halts) on illegal opcodes or memory timeout.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter (wraps modulo 2^CNT_W)
//  MEM_TIMEOUT  0   max cycles mem_req may wait for mem_ready; 0 = no timeout
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  ir           in   32     instruction register contents (valid from DECODE onward)
//  branch_taken in   1      comparator result for current B-type funct3
//  mem_ready    in   1      memory completes request this cycle
//  mem_req      out  1      memory request, held until mem_ready
//  mem_we       out  1      store request (qualifies mem_req)
//  mem_addr_sel out  1      0=PC, 1=ALU result
//  ir_we        out  1      latch mem rdata into IR
//  imm_sel      out  3      0=none,1=I,2=S,3=B,4=J,5=U
//  alu_a_sel    out  2      0=rs1, 1=PC, 2=zero
//  alu_b_sel    out  1      0=rs2, 1=imm
//  alu_op       out  2      0=ADD, 2=decode funct3/funct7 (R / I-ALU)
//  pc_we        out  1      PC update enable
//  pc_sel       out  2      0=PC+4, 1=ALU&~1, 2=PC+imm
//  reg_we       out  1      register-file write enable (ignored by regfile for rd=x0)
//  wb_sel       out  2      0=ALU, 1=mem rdata, 2=PC+4
//  instr_done   out  1      one-cycle pulse on the retiring cycle
//  trap         out  1      high while in TRAP
//  retired_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state; outputs combinational from state, ir, mem_ready, branch_taken.
//  rst: state=FETCH, retired_cnt=0, timeout counter=0. While rst is high, all outputs are 0. Reset mid-transaction abandons it (no retire, no writes).
//  Outputs not listed for a state are 0.
//  FETCH: mem_req=1, addr_sel=0. On mem_ready: ir_we=1, go to DECODE. Zero-wait ready (same cycle as req) is legal.
//  DECODE: classify ir[6:0]. Legal: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111. Legal -> EXEC; other -> TRAP.
//  EXEC by class (imm_sel follows format in EXEC, MEM and WB):
//   R: a=rs1, b=rs2, op=2 -> WB.
//   I-ALU: a=rs1, b=imm, op=2 -> WB.
//   LUI: a=zero, b=imm, op=0 -> WB.
//   AUIPC: a=PC, b=imm, op=0 -> WB.
//   LOAD/STORE: a=rs1, b=imm, op=0 -> MEM.
//   BRANCH: pc_we=1, pc_sel=branch_taken?2:0; retire -> FETCH.
//   JAL: pc_we, pc_sel=2, reg_we, wb_sel=2; retire -> FETCH.
//   JALR: a=rs1, b=imm, op=0, pc_we, pc_sel=1, reg_we, wb_sel=2; retire -> FETCH. Link value uses the pre-update PC.
//   FENCE: pc_we, pc_sel=0; retire -> FETCH.
//  MEM: mem_req=1, addr_sel=1, ALU operands held as in EXEC, mem_we=1 for store.
//   On mem_ready: load -> WB; store -> pc_we, pc_sel=0, retire -> FETCH.
//  WB: reg_we=1, wb_sel=1 for load else 0; ALU operands held; pc_we, pc_sel=0; retire -> FETCH.
//  Retire: instr_done=1 for exactly one cycle; retired_cnt+1 at that edge (wraps).
//  Timeout (MEM_TIMEOUT>0): counter clears whenever mem_req is 0 or mem_ready is 1. If MEM_TIMEOUT consecutive cycles pass with mem_req=1 and mem_ready=0 -> TRAP next edge.
//  TRAP: trap=1, all enables 0, mem_ready ignored; exit only via rst.
//  mem_ready outside FETCH/MEM is ignored.
// TESTING
//  ADDI x1,x0,5 (0x00500093), zero-wait mem -> FETCH,DECODE,EXEC,WB (4 cycles); WB: reg_we=1, wb_sel=0, pc_we=1, pc_sel=0; retired_cnt=1.
//  LW (0x0000A103), mem_ready delayed 3 cycles in MEM -> mem_req held for 4 cycles with addr_sel=1; WB: wb_sel=1; single instr_done.
//  BEQ taken/not taken (0x00208463) -> EXEC: pc_sel=2 / pc_sel=0, pc_we=1, reg_we=0; back to FETCH.
//  JAL (0x008000EF) -> EXEC: pc_sel=2, reg_we=1, wb_sel=2, imm_sel=4; FETCH next.
//  ir=0x00000073 (SYSTEM) -> TRAP after DECODE, trap=1 held, no retire; rst -> FETCH, retired_cnt=0.
//  MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles; rst asserted mid-MEM store -> no mem_we afterwards, FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I datapath (shared ALU, single memory port).
// Sequences FETCH/DECODE/EXEC/MEM/WB, counts retired instructions and halts in
// TRAP on an illegal opcode or a memory request that waits too long.
//
// Memory handshake: mem_req is held high until a cycle in which mem_ready is
// high; that cycle completes the transfer. mem_ready is only looked at while
// mem_req is high (FETCH and MEM); in every other state it is ignored.
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic [2:0]       imm_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             instr_done,
    output logic             trap,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_FENCE, C_ILLEGAL
    } iclass_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1; the next waiting cycle traps.
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state, state_next;
    iclass_t          cls;
    logic [2:0]       cls_imm;
    logic [1:0]       cls_a;
    logic             cls_b;
    logic [1:0]       cls_op;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             mem_wait;
    logic             to_hit;
    logic             unused_ir_bits;

    // Only the opcode field steers the sequencer; the rest of ir feeds the datapath.
    assign unused_ir_bits = ^ir[31:7];

    assign mem_wait = mem_req & ~mem_ready;
    assign to_hit   = (MEM_TIMEOUT > 0) && mem_wait && (to_cnt == TO_LAST);

    // Opcode classification plus the immediate format and ALU operands for that class.
    // FENCE carries no immediate the datapath uses, so it selects "none".
    always_comb begin
        cls     = C_ILLEGAL;
        cls_imm = 3'd0;
        cls_a   = 2'd0;
        cls_b   = 1'b0;
        cls_op  = 2'd0;
        case (ir[6:0])
            7'b0110011: begin cls = C_R;      cls_op = 2'd2; end
            7'b0010011: begin cls = C_IALU;   cls_imm = 3'd1; cls_b = 1'b1; cls_op = 2'd2; end
            7'b0000011: begin cls = C_LOAD;   cls_imm = 3'd1; cls_b = 1'b1; end
            7'b0100011: begin cls = C_STORE;  cls_imm = 3'd2; cls_b = 1'b1; end
            7'b1100011: begin cls = C_BRANCH; cls_imm = 3'd3; end
            7'b1101111: begin cls = C_JAL;    cls_imm = 3'd4; end
            7'b1100111: begin cls = C_JALR;   cls_imm = 3'd1; cls_b = 1'b1; end
            7'b0110111: begin cls = C_LUI;    cls_imm = 3'd5; cls_a = 2'd2; cls_b = 1'b1; end
            7'b0010111: begin cls = C_AUIPC;  cls_imm = 3'd5; cls_a = 2'd1; cls_b = 1'b1; end
            7'b0001111: begin cls = C_FENCE; end
            default:    cls = C_ILLEGAL;
        endcase
    end

    // Next-state and control outputs; everything is forced low while rst is high.
    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        imm_sel      = 3'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        alu_op       = 2'd0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        instr_done   = 1'b0;
        trap         = 1'b0;
        if (rst) begin
            state_next = S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_next = (cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    imm_sel = cls_imm;
                    case (cls)
                        C_R, C_IALU, C_LUI, C_AUIPC: begin
                            alu_a_sel  = cls_a;
                            alu_b_sel  = cls_b;
                            alu_op     = cls_op;
                            state_next = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_a_sel  = cls_a;
                            alu_b_sel  = cls_b;
                            alu_op     = cls_op;
                            state_next = S_MEM;
                        end
                        C_BRANCH: begin
                            pc_we      = 1'b1;
                            pc_sel     = branch_taken ? 2'd2 : 2'd0;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        C_JAL: begin
                            pc_we      = 1'b1;
                            pc_sel     = 2'd2;
                            reg_we     = 1'b1;
                            wb_sel     = 2'd2;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        C_JALR: begin
                            // Link (PC+4) is written this same edge, from the old PC.
                            alu_a_sel  = cls_a;
                            alu_b_sel  = cls_b;
                            alu_op     = cls_op;
                            pc_we      = 1'b1;
                            pc_sel     = 2'd1;
                            reg_we     = 1'b1;
                            wb_sel     = 2'd2;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        C_FENCE: begin
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        default: state_next = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls == C_STORE);
                    imm_sel      = cls_imm;
                    alu_a_sel    = cls_a;
                    alu_b_sel    = cls_b;
                    alu_op       = cls_op;
                    if (mem_ready) begin
                        if (cls == C_STORE) begin
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            state_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    imm_sel    = cls_imm;
                    alu_a_sel  = cls_a;
                    alu_b_sel  = cls_b;
                    alu_op     = cls_op;
                    reg_we     = 1'b1;
                    wb_sel     = (cls == C_LOAD) ? 2'd1 : 2'd0;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: state_next = S_FETCH;
            endcase
            if (to_hit) begin
                state_next = S_TRAP;
            end
        end
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (instr_done) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Consecutive-wait counter for the memory timeout; clears on any non-waiting cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((MEM_TIMEOUT > 0) && mem_wait && !to_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign retired_cnt = rst ? '0 : cnt;
    assign dbg_state   = rst ? S_FETCH : state;

endmodule
